// File: rtl/lcd_write_scheduler.sv
// lcd_write_scheduler
//   Buffers character / clear-screen requests from the ALU LCD instruction
//   path and sequences them onto the LCD driver's single-write/ready
//   handshake. Tracks the cursor on a COLS x 2 display and inserts
//   set-DDRAM-address commands when a line boundary is crossed.
//
// Ports
//   Clock, Reset          system clock, async active-high reset
//   iWrite, iData         push a character (0x0A = newline)
//   iClear                flush buffer and clear the display
//   oFull, oEmpty         FIFO status (registered)
//   oBusy                 FSM not idle or FIFO not empty
//   oOverflow             sticky: write attempted while full
//   oLcdWrite/RS/Data     strobe, register select and byte to the driver
//   iLcdReady             driver can accept a strobe
//   iLcdInitialized       driver power-on sequence complete
module lcd_write_scheduler #(
   parameter int FIFO_DEPTH = 8,
   parameter int COLS       = 16
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       iWrite,
   input  logic [7:0] iData,
   input  logic       iClear,
   output logic       oFull,
   output logic       oEmpty,
   output logic       oBusy,
   output logic       oOverflow,
   output logic       oLcdWrite,
   output logic       oLcdRS,
   output logic [7:0] oLcdData,
   input  logic       iLcdReady,
   input  logic       iLcdInitialized
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      INIT_WAIT,
      IDLE,
      STROBE,
      GUARD,
      WAIT
   } stateT;

   stateT         state, stateNext;

   logic [7:0]    fifoMem [FIFO_DEPTH];
   logic [AW-1:0] wrPtr, rdPtr;
   logic [AW:0]   count, countNext;
   logic          fifoEmpty;
   logic [7:0]    headByte;
   logic          doPush, doPop;

   logic [4:0]    cursor, cursorNext;
   logic          addrPending, addrPendingNext;
   logic          clearPending, clearPendingNext;
   logic [7:0]    wrByte, wrByteNext;
   logic          wrRs, wrRsNext;

   assign fifoEmpty = (count == '0);
   assign headByte  = fifoMem[rdPtr];
   // A clear discards a simultaneous write without flagging overflow.
   assign doPush    = iWrite && !oFull && !iClear;
   assign oBusy     = (state != IDLE) || !oEmpty;

   always_comb begin
      if (iClear)
         countNext = '0;
      else
         countNext = count + (AW+1)'(doPush) - (AW+1)'(doPop);
   end

   // ------------------------------------------------------------------
   // FSM next-state and work selection
   // ------------------------------------------------------------------
   always_comb begin
      stateNext        = state;
      doPop            = 1'b0;
      cursorNext       = cursor;
      addrPendingNext  = addrPending;
      clearPendingNext = clearPending;
      wrByteNext       = wrByte;
      wrRsNext         = wrRs;

      case (state)
         INIT_WAIT: if (iLcdInitialized) stateNext = IDLE;

         // A clear arriving this cycle takes precedence over any pop/issue,
         // so the flushed FIFO head is never consumed.
         IDLE: if (!iClear && iLcdReady) begin
            if (clearPending) begin
               wrByteNext       = 8'h01;
               wrRsNext         = 1'b0;
               clearPendingNext = 1'b0;
               stateNext        = STROBE;
            end else if (addrPending) begin
               wrByteNext      = (cursor < 5'(COLS)) ? 8'h80 : 8'hC0;
               wrRsNext        = 1'b0;
               addrPendingNext = 1'b0;
               stateNext       = STROBE;
            end else if (!fifoEmpty) begin
               doPop = 1'b1;
               if (headByte == 8'h0A) begin
                  // Newline only moves the cursor; the address command
                  // follows on a later IDLE visit.
                  cursorNext      = (cursor < 5'(COLS)) ? 5'(COLS) : 5'd0;
                  addrPendingNext = 1'b1;
               end else begin
                  wrByteNext = headByte;
                  wrRsNext   = 1'b1;
                  stateNext  = STROBE;
                  if (cursor == 5'(COLS-1)) begin
                     cursorNext      = 5'(COLS);
                     addrPendingNext = 1'b1;
                  end else if (cursor == 5'(2*COLS-1)) begin
                     cursorNext      = 5'd0;
                     addrPendingNext = 1'b1;
                  end else begin
                     cursorNext = cursor + 5'd1;
                  end
               end
            end
         end

         STROBE:  stateNext = GUARD;
         GUARD:   stateNext = WAIT;   // ready ignored while driver reacts
         WAIT:    if (iLcdReady) stateNext = IDLE;
         default: stateNext = INIT_WAIT;
      endcase

      if (iClear) begin
         clearPendingNext = 1'b1;
         cursorNext       = 5'd0;
         addrPendingNext  = 1'b0;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state        <= INIT_WAIT;
         cursor       <= 5'd0;
         addrPending  <= 1'b0;
         clearPending <= 1'b0;
         wrByte       <= 8'h00;
         wrRs         <= 1'b0;
      end else begin
         state        <= stateNext;
         cursor       <= cursorNext;
         addrPending  <= addrPendingNext;
         clearPending <= clearPendingNext;
         wrByte       <= wrByteNext;
         wrRs         <= wrRsNext;
      end
   end

   // ------------------------------------------------------------------
   // FIFO storage and pointers
   // ------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (doPush) fifoMem[wrPtr] <= iData;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         count     <= '0;
         oFull     <= 1'b0;
         oEmpty    <= 1'b1;
         oOverflow <= 1'b0;
      end else begin
         count  <= countNext;
         oFull  <= (countNext == (AW+1)'(FIFO_DEPTH));
         oEmpty <= (countNext == '0);
         if (iWrite && oFull && !iClear) oOverflow <= 1'b1;
         if (iClear) begin
            wrPtr <= '0;
            rdPtr <= '0;
         end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Registered driver outputs: STROBE loads them, so the pulse is seen
   // during the cycle after STROBE and data holds until the next load.
   // ------------------------------------------------------------------
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         oLcdWrite <= 1'b0;
         oLcdRS    <= 1'b0;
         oLcdData  <= 8'h00;
      end else begin
         oLcdWrite <= (state == STROBE);
         if (state == STROBE) begin
            oLcdRS   <= wrRs;
            oLcdData <= wrByte;
         end
      end
   end

endmodule
